mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 3: number of request channels, 2..8.
REQ-002 Parameter ADDR_W, default 32: address width, at least 18.
REQ-003 Parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with channel 0 highest.
REQ-004 in_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 in_rst  input  1  synchronous, active-high reset.
REQ-006 in_rdy  input  1  global enable; while low, all state and outputs hold.
REQ-007 in_flush_enable  input  1  pipeline flush (branch mispredict).
REQ-008 io_buffer_full  input  1  IO sink cannot accept traffic.
REQ-009 in_mem_data  input  8  read byte; returns one cycle after its address is driven.
REQ-010 out_mem_data  output  8  write byte.
REQ-011 out_mem_addr  output  ADDR_W  byte address, registered.
REQ-012 out_mem_wr_signal  output  1  1 = write, 0 = read, registered.
REQ-013 in_req_valid  input  NUM_CH  per-channel request strobe; level-sensitive.
REQ-014 out_req_ready  output  NUM_CH  per-channel slot free.
REQ-015 in_req_addr  input  NUM_CH*ADDR_W  packed request addresses; channel i occupies slice i.
REQ-016 in_req_wr  input  NUM_CH  1 = store.
REQ-017 in_req_style  input  NUM_CH*2  access size: 00 byte, 01 half-word, 10 word; 11 is treated as word.
REQ-018 in_req_wdata  input  NUM_CH*32  store data, little-endian.
REQ-019 out_rsp_valid  output  NUM_CH  one-hot, one-cycle completion pulse.
REQ-020 out_rsp_data  output  32  load data, zero-extended; 0 for stores.

Function
REQ-021 Each channel SHALL hold a one-entry request buffer; out_req_ready[i] SHALL be the inverse of buffer i's valid bit.
REQ-022 A request SHALL be captured at an edge where in_rdy, in_req_valid[i] and out_req_ready[i] are all high and in_flush_enable is low.
REQ-023 An address SHALL be IO when bits [17:16] equal 2'b11; all other addresses are memory.
REQ-024 A buffered channel SHALL be eligible for grant unless it is blocked:
- an IO load is blocked while io_buffer_full is high;
- an IO store is blocked while io_buffer_full is high or any operation is in flight, including read data still outstanding.
REQ-025 With RR_EN=1, the search SHALL start at (last granted + 1) mod NUM_CH. With RR_EN=0, the lowest eligible index SHALL win.
REQ-026 The engine SHALL have two states: IDLE and XFER. A grant SHALL be issued from IDLE, or on the last byte of XFER (back-to-back, no bubble).
REQ-027 The byte count n SHALL be 1, 2 or 4 according to the request style. In cycle T+k, for k = 0..n-1, the block SHALL drive:
- out_mem_addr = addr + k, computed modulo 2^ADDR_W;
- out_mem_data = wdata[8k+7:8k];
- out_mem_wr_signal = in_req_wr.
REQ-028 Load byte k SHALL be sampled from in_mem_data in cycle T+k+1 and assembled little-endian.
REQ-029 In cycle T+n+1 the block SHALL assert out_rsp_valid[i] for one cycle with out_rsp_data valid. Buffer i SHALL clear on that same edge, so ready rises in cycle T+n+1.
REQ-030 With no grant, the block SHALL drive out_mem_addr = 0 and out_mem_wr_signal = 0.
REQ-031 On flush (in_flush_enable high with in_rdy high):
- all pending, un-granted buffers SHALL clear;
- an in-flight memory load SHALL abort, with no further addresses and no response;
- an in-flight IO load SHALL complete and return its response;
- an in-flight store SHALL finish its remaining bytes with no response;
- no new request SHALL be captured that cycle.
REQ-032 The arbiter pointer SHALL advance only on grant, and SHALL be unchanged by flush.

Reset
REQ-033 When in_rst is high at an edge, the block SHALL:
- go to IDLE;
- clear all buffers, so out_req_ready is all ones;
- drive out_rsp_valid = 0, out_rsp_data = 0, out_mem_addr = 0, out_mem_data = 0, out_mem_wr_signal = 0;
- set the pointer to NUM_CH-1, so channel 0 is searched first.
REQ-034 Reset SHALL take precedence over in_rdy and flush, and SHALL abort any transfer mid-operation.

Verification
REQ-035 Channel 1 word load at 0x100, memory returning 11,22,33,44 -> addresses 0x100..0x103 in cycles T..T+3; out_rsp_valid=3'b010 with 0x44332211 at T+5.
REQ-036 Channels 0, 1 and 2 all request in the same cycle with RR_EN=1 -> grants go 0, 1, 2, then 0 again on re-request; with RR_EN=0 and continuous channel-0 requests, channel 2 is never granted.
REQ-037 Half-word store of 0xBEEF to 0x30000 while io_buffer_full=1 -> no write issued; after io_buffer_full drops with the engine idle -> write 0xEF to 0x30000, then 0xBE to 0x30001.
REQ-038 Flush at T+1 of a memory word load -> no further addresses, no response, all ready bits 1 by T+2; flush during an IO byte load -> its response still pulses.
REQ-039 in_rdy held low for 3 cycles mid-word-store -> out_mem_addr and out_mem_data hold; the sequence resumes at the next byte with no duplication or loss.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel byte-serial memory arbiter.
//
// Each channel has a one-entry request buffer. Granted requests are issued
// one byte per cycle on the registered memory port. Read data returns one
// cycle after its address and is assembled little-endian. A one-hot
// completion pulse is raised one cycle after the last read byte is sampled.
//
// Ports:
//   in_clk, in_rst        clock, synchronous active-high reset
//   in_rdy                global enable; all state holds while low
//   in_flush_enable       drop pending work (see flush handling below)
//   io_buffer_full        IO sink back-pressure
//   in_mem_data           read byte from memory
//   out_mem_data/addr/wr_signal  registered byte-wide memory port
//   in_req_*              per-channel request (valid/addr/wr/style/wdata)
//   out_req_ready         per-channel buffer free
//   out_rsp_valid/data    one-hot completion pulse and load data
module mem_arbiter #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RR_EN  = 1
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_rdy,
  input  logic                     in_flush_enable,
  input  logic                     io_buffer_full,
  input  logic [7:0]               in_mem_data,
  output logic [7:0]               out_mem_data,
  output logic [ADDR_W-1:0]        out_mem_addr,
  output logic                     out_mem_wr_signal,
  input  logic [NUM_CH-1:0]        in_req_valid,
  output logic [NUM_CH-1:0]        out_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] in_req_addr,
  input  logic [NUM_CH-1:0]        in_req_wr,
  input  logic [NUM_CH*2-1:0]      in_req_style,
  input  logic [NUM_CH*32-1:0]     in_req_wdata,
  output logic [NUM_CH-1:0]        out_rsp_valid,
  output logic [31:0]              out_rsp_data
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {StIdle, StXfer} state_e;
  state_e state_q, state_d;

  // Request buffers. gnt_q marks a buffer whose transfer is in flight;
  // quiet_q marks a store that must finish without a response after a flush.
  logic [NUM_CH-1:0] buf_v_q, buf_v_d, buf_wr_q, buf_wr_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d, quiet_q, quiet_d;
  logic [ADDR_W-1:0] buf_addr_q  [NUM_CH];
  logic [ADDR_W-1:0] buf_addr_d  [NUM_CH];
  logic [1:0]        buf_style_q [NUM_CH];
  logic [1:0]        buf_style_d [NUM_CH];
  logic [31:0]       buf_wdata_q [NUM_CH];
  logic [31:0]       buf_wdata_d [NUM_CH];

  // Issue engine.
  logic [CH_W-1:0]   ptr_q, ptr_d, cur_ch_q, cur_ch_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic              wr_q, wr_d;

  // Sample stage: describes the byte whose read data is on in_mem_data now.
  logic              s_v_q, s_v_d, s_last_q, s_last_d, s_load_q, s_load_d;
  logic [CH_W-1:0]   s_ch_q, s_ch_d;
  logic [1:0]        s_idx_q, s_idx_d;

  logic [31:0]       asm_q, asm_d, rsp_data_q, rsp_data_d;
  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;

  // Per-channel classification and eligibility.
  logic [NUM_CH-1:0] is_io, mem_load, elig;
  logic [1:0]        last_idx [NUM_CH];
  logic              busy;

  always_comb begin
    busy = (state_q == StXfer) | s_v_q | (|gnt_q);
    for (int i = 0; i < NUM_CH; i++) begin
      is_io[i]    = buf_addr_q[i][17:16] == 2'b11;
      mem_load[i] = ~buf_wr_q[i] & ~is_io[i];
      last_idx[i] = buf_style_q[i][1] ? 2'd3 : (buf_style_q[i][0] ? 2'd1 : 2'd0);
      elig[i]     = buf_v_q[i] & ~gnt_q[i] & ~(is_io[i] & io_buffer_full) &
                    ~(is_io[i] & buf_wr_q[i] & busy);
    end
  end

  // Arbiter: round-robin starts after the last grant, else lowest index wins.
  logic            gnt_found;
  logic [CH_W-1:0] gnt_idx;
  logic [31:0]     idx;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = (RR_EN != 0) ? (32'(ptr_q) + 32'(off) + 32'd1) % NUM_CH : 32'(off);
      if (!gnt_found && elig[CH_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
  end

  logic flush, cur_last, abort_cur, do_grant, s_kill, s_quiet;

  always_comb begin
    flush     = in_flush_enable;
    cur_last  = cnt_q == last_idx[cur_ch_q];
    abort_cur = flush & (state_q == StXfer) & mem_load[cur_ch_q];
    // Grant from idle or on the last byte, so transfers run back-to-back.
    do_grant  = gnt_found & ~flush & ((state_q == StIdle) | cur_last);
    s_kill    = flush & mem_load[s_ch_q];
    s_quiet   = quiet_q[s_ch_q] | (flush & buf_wr_q[s_ch_q]);
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (do_grant) state_d = StXfer;
      StXfer: begin
        if (abort_cur) state_d = StIdle;
        else if (cur_last && !do_grant) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= StIdle;
    else if (in_rdy) state_q <= state_d;
  end

  // Datapath next state.
  logic [31:0] asm_new;

  always_comb begin
    buf_v_d     = buf_v_q;
    buf_wr_d    = buf_wr_q;
    buf_addr_d  = buf_addr_q;
    buf_style_d = buf_style_q;
    buf_wdata_d = buf_wdata_q;
    gnt_d       = gnt_q;
    quiet_d     = quiet_q;
    ptr_d       = ptr_q;
    cur_ch_d    = cur_ch_q;
    cnt_d       = '0;
    addr_d      = '0;
    wdat_d      = '0;
    wr_d        = 1'b0;
    asm_d       = asm_q;
    asm_new     = asm_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = '0;

    if (do_grant) begin
      cur_ch_d = gnt_idx;
      addr_d   = buf_addr_q[gnt_idx];
      wdat_d   = buf_wdata_q[gnt_idx][7:0];
      wr_d     = buf_wr_q[gnt_idx];
      ptr_d    = gnt_idx;
    end else if ((state_q == StXfer) && !abort_cur && !cur_last) begin
      cnt_d  = cnt_q + 2'd1;
      addr_d = addr_q + ADDR_W'(1);
      wdat_d = 8'(buf_wdata_q[cur_ch_q] >> {cnt_d, 3'b000});
      wr_d   = wr_q;
    end

    s_v_d    = (state_q == StXfer) & ~abort_cur;
    s_ch_d   = cur_ch_q;
    s_idx_d  = cnt_q;
    s_last_d = cur_last;
    s_load_d = ~buf_wr_q[cur_ch_q];

    // Flush keeps only in-flight IO loads and stores; stores go quiet.
    if (flush) begin
      buf_v_d = buf_v_d & gnt_q & ~mem_load;
      gnt_d   = gnt_d & ~mem_load;
      quiet_d = quiet_d | (gnt_q & buf_wr_q);
    end

    if (s_v_q && !s_kill) begin
      if (s_load_q) begin
        asm_new = ((s_idx_q == 2'd0) ? 32'd0 : asm_q) |
                  (32'(in_mem_data) << {s_idx_q, 3'b000});
        asm_d   = asm_new;
      end
      if (s_last_q) begin
        if (!s_quiet) begin
          rsp_valid_d[s_ch_q] = 1'b1;
          rsp_data_d          = s_load_q ? asm_new : 32'd0;
        end
        buf_v_d[s_ch_q] = 1'b0;
        gnt_d[s_ch_q]   = 1'b0;
        quiet_d[s_ch_q] = 1'b0;
      end
    end

    if (do_grant) gnt_d[gnt_idx] = 1'b1;

    for (int i = 0; i < NUM_CH; i++) begin
      if (!flush && in_req_valid[i] && !buf_v_q[i]) begin
        buf_v_d[i]     = 1'b1;
        buf_wr_d[i]    = in_req_wr[i];
        buf_addr_d[i]  = in_req_addr[i*ADDR_W +: ADDR_W];
        buf_style_d[i] = in_req_style[i*2 +: 2];
        buf_wdata_d[i] = in_req_wdata[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      buf_v_q     <= '0;
      buf_wr_q    <= '0;
      gnt_q       <= '0;
      quiet_q     <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
      cur_ch_q    <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      wr_q        <= 1'b0;
      s_v_q       <= 1'b0;
      s_ch_q      <= '0;
      s_idx_q     <= '0;
      s_last_q    <= 1'b0;
      s_load_q    <= 1'b0;
      asm_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else if (in_rdy) begin
      buf_v_q     <= buf_v_d;
      buf_wr_q    <= buf_wr_d;
      gnt_q       <= gnt_d;
      quiet_q     <= quiet_d;
      ptr_q       <= ptr_d;
      cur_ch_q    <= cur_ch_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      wr_q        <= wr_d;
      s_v_q       <= s_v_d;
      s_ch_q      <= s_ch_d;
      s_idx_q     <= s_idx_d;
      s_last_q    <= s_last_d;
      s_load_q    <= s_load_d;
      asm_q       <= asm_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Payload fields only matter while the matching valid bit is set.
  always_ff @(posedge in_clk) begin
    if (in_rdy) begin
      buf_addr_q  <= buf_addr_d;
      buf_style_q <= buf_style_d;
      buf_wdata_q <= buf_wdata_d;
    end
  end

  // Outputs.
  always_comb begin
    out_req_ready     = ~buf_v_q;
    out_mem_addr      = addr_q;
    out_mem_data      = wdat_q;
    out_mem_wr_signal = wr_q;
    out_rsp_valid     = rsp_valid_q;
    out_rsp_data      = rsp_data_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance
// share all inputs; read data comes from a simple address-derived memory.
module tb_mem_arbiter;
  localparam int unsigned NCH = 3;
  localparam int unsigned AW  = 32;

  logic in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  logic             in_rst, in_rdy, in_flush_enable, io_buffer_full;
  logic [7:0]       in_mem_data;
  logic [NCH-1:0]   in_req_valid, in_req_wr;
  logic [NCH*AW-1:0] in_req_addr;
  logic [NCH*2-1:0] in_req_style;
  logic [NCH*32-1:0] in_req_wdata;

  logic [7:0]     rr_mem_data, fp_mem_data;
  logic [AW-1:0]  rr_mem_addr, fp_mem_addr;
  logic           rr_wr, fp_wr;
  logic [NCH-1:0] rr_ready, fp_ready, rr_rsp_valid, fp_rsp_valid;
  logic [31:0]    rr_rsp_data, fp_rsp_data;

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .RR_EN(1)) dut_rr (
    .in_clk(in_clk), .in_rst(in_rst), .in_rdy(in_rdy), .in_flush_enable(in_flush_enable),
    .io_buffer_full(io_buffer_full), .in_mem_data(in_mem_data), .out_mem_data(rr_mem_data),
    .out_mem_addr(rr_mem_addr), .out_mem_wr_signal(rr_wr), .in_req_valid(in_req_valid),
    .out_req_ready(rr_ready), .in_req_addr(in_req_addr), .in_req_wr(in_req_wr),
    .in_req_style(in_req_style), .in_req_wdata(in_req_wdata), .out_rsp_valid(rr_rsp_valid),
    .out_rsp_data(rr_rsp_data)
  );

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .RR_EN(0)) dut_fp (
    .in_clk(in_clk), .in_rst(in_rst), .in_rdy(in_rdy), .in_flush_enable(in_flush_enable),
    .io_buffer_full(io_buffer_full), .in_mem_data(in_mem_data), .out_mem_data(fp_mem_data),
    .out_mem_addr(fp_mem_addr), .out_mem_wr_signal(fp_wr), .in_req_valid(in_req_valid),
    .out_req_ready(fp_ready), .in_req_addr(in_req_addr), .in_req_wr(in_req_wr),
    .in_req_style(in_req_style), .in_req_wdata(in_req_wdata), .out_rsp_valid(fp_rsp_valid),
    .out_rsp_data(fp_rsp_data)
  );

  // Memory: byte at address a is 0x11 * (a[1:0] + 1), one cycle after the address.
  always @(posedge in_clk) in_mem_data <= 8'h11 * (8'(rr_mem_addr[1:0]) + 8'd1);

  // Grant monitor for the starvation run.
  logic mon_en = 1'b0;
  int rr_ch2_cnt = 0;
  int fp_ch2_cnt = 0;
  int fp_ch0_cnt = 0;
  always @(negedge in_clk) begin
    if (mon_en) begin
      if (rr_mem_addr == 32'h400) rr_ch2_cnt++;
      if (fp_mem_addr == 32'h400) fp_ch2_cnt++;
      if (fp_mem_addr == 32'h200) fp_ch0_cnt++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(negedge in_clk);
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a, input logic wr,
                         input logic [1:0] st, input logic [31:0] wd);
    in_req_addr[ch*AW +: AW]   = a;
    in_req_wr[ch]              = wr;
    in_req_style[ch*2 +: 2]    = st;
    in_req_wdata[ch*32 +: 32]  = wd;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    in_req_valid = '0;
    cyc();
    cyc();
    in_rst = 1'b0;
  endtask

  initial begin
    in_rst = 1'b1; in_rdy = 1'b1; in_flush_enable = 1'b0; io_buffer_full = 1'b0;
    in_req_valid = '0; in_req_wr = '0; in_req_addr = '0; in_req_style = '0;
    in_req_wdata = '0;
    do_reset();

    // Reset state.
    chk("rst_ready", rr_ready, 3'b111);
    chk("rst_rsp_valid", rr_rsp_valid, 3'b000);
    chk("rst_rsp_data", rr_rsp_data, 32'h0);
    chk("rst_addr", rr_mem_addr, 32'h0);
    chk("rst_wdata", rr_mem_data, 8'h0);
    chk("rst_wr", rr_wr, 1'b0);
    chk("rst_fp_ready", fp_ready, 3'b111);

    // Channel 1 word load at 0x100.
    set_req(1, 32'h100, 1'b0, 2'b10, 32'h0);
    in_req_valid = 3'b010;
    cyc();
    chk("ld_ready_low", rr_ready, 3'b101);
    chk("ld_no_addr_yet", rr_mem_addr, 32'h0);
    in_req_valid = '0;
    cyc(); chk("ld_addr0", rr_mem_addr, 32'h100); chk("ld_wr0", rr_wr, 1'b0);
    cyc(); chk("ld_addr1", rr_mem_addr, 32'h101);
    cyc(); chk("ld_addr2", rr_mem_addr, 32'h102);
    cyc(); chk("ld_addr3", rr_mem_addr, 32'h103);
    cyc(); chk("ld_addr_idle", rr_mem_addr, 32'h0); chk("ld_rsp_early", rr_rsp_valid, 3'b000);
    cyc(); chk("ld_rsp_valid", rr_rsp_valid, 3'b010); chk("ld_rsp_data", rr_rsp_data, 32'h44332211);
    cyc(); chk("ld_rsp_once", rr_rsp_valid, 3'b000); chk("ld_ready_back", rr_ready, 3'b111);

    // Reset mid-transfer aborts it.
    set_req(0, 32'h100, 1'b0, 2'b10, 32'h0);
    in_req_valid = 3'b001;
    cyc(); in_req_valid = '0;
    cyc(); chk("rstmid_addr0", rr_mem_addr, 32'h100);
    cyc(); in_rst = 1'b1;
    cyc(); in_rst = 1'b0;
    chk("rstmid_addr", rr_mem_addr, 32'h0);
    chk("rstmid_ready", rr_ready, 3'b111);
    for (int i = 0; i < 6; i++) begin
      cyc(); chk("rstmid_no_rsp", rr_rsp_valid, 3'b000);
    end

    // Three simultaneous byte loads: grants 0, 1, 2 back-to-back.
    set_req(0, 32'h200, 1'b0, 2'b00, 32'h0);
    set_req(1, 32'h300, 1'b0, 2'b00, 32'h0);
    set_req(2, 32'h400, 1'b0, 2'b00, 32'h0);
    in_req_valid = 3'b111;
    cyc(); in_req_valid = '0;
    cyc(); chk("rr_g0", rr_mem_addr, 32'h200); chk("fp_g0", fp_mem_addr, 32'h200);
    cyc(); chk("rr_g1", rr_mem_addr, 32'h300);
    cyc(); chk("rr_g2", rr_mem_addr, 32'h400);
    chk("rr_rsp0", rr_rsp_valid, 3'b001); chk("rr_rsp0_data", rr_rsp_data, 32'h11);
    cyc(); chk("rr_idle", rr_mem_addr, 32'h0); chk("rr_rsp1", rr_rsp_valid, 3'b010);
    cyc(); chk("rr_rsp2", rr_rsp_valid, 3'b100);
    cyc();
    // Re-request channel 0: searched first again.
    in_req_valid = 3'b001;
    cyc(); in_req_valid = '0;
    cyc(); chk("rr_regrant0", rr_mem_addr, 32'h200); chk("fp_regrant0", fp_mem_addr, 32'h200);
    repeat (4) cyc();
    // Channels 0 and 1 together: round-robin favours 1, fixed priority 0.
    in_req_valid = 3'b011;
    cyc(); in_req_valid = '0;
    cyc(); chk("rr_rot_first", rr_mem_addr, 32'h300); chk("fp_pri_first", fp_mem_addr, 32'h200);
    cyc(); chk("rr_rot_second", rr_mem_addr, 32'h200); chk("fp_pri_second", fp_mem_addr, 32'h300);
    repeat (4) cyc();

    // Continuous word loads on all channels: fixed priority starves channel 2.
    set_req(0, 32'h200, 1'b0, 2'b10, 32'h0);
    set_req(1, 32'h300, 1'b0, 2'b10, 32'h0);
    set_req(2, 32'h400, 1'b0, 2'b10, 32'h0);
    in_req_valid = 3'b111;
    mon_en = 1'b1;
    repeat (40) cyc();
    mon_en = 1'b0;
    in_req_valid = '0;
    chk("fp_ch2_starved", fp_ch2_cnt, 0);
    chk("rr_ch2_served", rr_ch2_cnt > 0, 1'b1);
    chk("fp_ch0_served", fp_ch0_cnt >= 3, 1'b1);
    do_reset();

    // IO half-word store held off by io_buffer_full.
    io_buffer_full = 1'b1;
    set_req(0, 32'h30000, 1'b1, 2'b01, 32'h0000BEEF);
    in_req_valid = 3'b001;
    cyc(); in_req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("io_blk_wr", rr_wr, 1'b0); chk("io_blk_addr", rr_mem_addr, 32'h0);
    end
    io_buffer_full = 1'b0;
    cyc(); chk("io_st_addr0", rr_mem_addr, 32'h30000); chk("io_st_data0", rr_mem_data, 8'hEF);
    chk("io_st_wr0", rr_wr, 1'b1);
    cyc(); chk("io_st_addr1", rr_mem_addr, 32'h30001); chk("io_st_data1", rr_mem_data, 8'hBE);
    chk("io_st_wr1", rr_wr, 1'b1);
    cyc(); chk("io_st_idle_addr", rr_mem_addr, 32'h0); chk("io_st_idle_wr", rr_wr, 1'b0);
    cyc(); chk("io_st_rsp", rr_rsp_valid, 3'b001); chk("io_st_rsp_data", rr_rsp_data, 32'h0);
    cyc();

    // Flush at T+1 of a memory word load, with channel 2 pending.
    set_req(1, 32'h100, 1'b0, 2'b10, 32'h0);
    set_req(2, 32'h400, 1'b0, 2'b10, 32'h0);
    in_req_valid = 3'b110;
    cyc(); in_req_valid = '0;
    cyc(); chk("fl_addr0", rr_mem_addr, 32'h100);
    cyc(); chk("fl_addr1", rr_mem_addr, 32'h101);
    in_flush_enable = 1'b1;
    cyc(); in_flush_enable = 1'b0;
    chk("fl_addr_stop", rr_mem_addr, 32'h0);
    chk("fl_ready", rr_ready, 3'b111);
    for (int i = 0; i < 6; i++) begin
      cyc(); chk("fl_no_rsp", rr_rsp_valid, 3'b000); chk("fl_no_addr", rr_mem_addr, 32'h0);
    end

    // Flush during an IO byte load still returns its response.
    set_req(0, 32'h30012, 1'b0, 2'b00, 32'h0);
    in_req_valid = 3'b001;
    cyc(); in_req_valid = '0;
    cyc(); chk("fio_addr", rr_mem_addr, 32'h30012);
    in_flush_enable = 1'b1;
    cyc(); in_flush_enable = 1'b0;
    cyc(); chk("fio_rsp", rr_rsp_valid, 3'b001); chk("fio_rsp_data", rr_rsp_data, 32'h33);
    cyc();

    // in_rdy low for three cycles in the middle of a word store.
    set_req(0, 32'h500, 1'b1, 2'b10, 32'hDDCCBBAA);
    in_req_valid = 3'b001;
    cyc(); in_req_valid = '0;
    cyc(); chk("st_addr0", rr_mem_addr, 32'h500); chk("st_data0", rr_mem_data, 8'hAA);
    chk("st_wr0", rr_wr, 1'b1);
    cyc(); chk("st_addr1", rr_mem_addr, 32'h501); chk("st_data1", rr_mem_data, 8'hBB);
    in_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("st_hold_addr", rr_mem_addr, 32'h501); chk("st_hold_data", rr_mem_data, 8'hBB);
    end
    in_rdy = 1'b1;
    cyc(); chk("st_addr2", rr_mem_addr, 32'h502); chk("st_data2", rr_mem_data, 8'hCC);
    cyc(); chk("st_addr3", rr_mem_addr, 32'h503); chk("st_data3", rr_mem_data, 8'hDD);
    chk("st_wr3", rr_wr, 1'b1);
    cyc(); chk("st_idle_addr", rr_mem_addr, 32'h0); chk("st_idle_wr", rr_wr, 1'b0);
    cyc(); chk("st_rsp", rr_rsp_valid, 3'b001); chk("st_rsp_data", rr_rsp_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
